mod_acc: RTL and testbench
==========================

MOD_ACC -- requirements
Module: mod_acc

Interface
REQ-001 SHALL have parameter OP_W, default 64, operand and result width.
REQ-002 SHALL have parameter MOD_M [OP_W-1:0], default 2**OP_W-2**(OP_W/2)+1, modulus with bit OP_W-1 set.
REQ-003 SHALL have parameter CNT_W, default 16, element-counter width.
REQ-004 SHALL have parameter IN_PIPE (bit), default 1, input register stage enable.
REQ-005 SHALL have parameter OUT_PIPE (bit), default 1, output register stage enable.
REQ-006 SHALL have parameter SIDE_W, default 0, side-data width (0 = unused).
REQ-007 SHALL have ports: clk input 1 system clock; s_rst_n input 1 synchronous active-low reset.
REQ-008 SHALL have ports: in_avail input 1 element valid; in_data input OP_W element (< MOD_M); in_sop input 1 first element; in_eop input 1 last element; in_side input SIDE_W packet side data.
REQ-009 SHALL have ports: out_avail output 1 result valid; out_data output OP_W packet sum mod MOD_M; out_cnt output CNT_W element count; out_side output SIDE_W side data captured at sop; err output 1 protocol-error pulse.

Function
REQ-010 SHALL compute, per packet (sop..eop), out_data = sum of all in_data mod MOD_M; no backpressure, one element per cycle max.
REQ-011 SHALL perform each accumulation step as c = acc + in_data (OP_W+1 bits), c - MOD_M (OP_W+2 bits), selecting c when the difference is negative, else the difference; one step per cycle, no multi-cycle feedback.
REQ-012 SHALL implement FSM IDLE/ACC: IDLE + avail + sop + !eop -> ACC; ACC + avail + eop -> IDLE; all other cases hold state unless REQ-015/016 apply.
REQ-013 SHALL on sop load acc = in_data, cnt = 1, capture in_side; in ACC each non-sop avail element adds to acc and increments cnt.
REQ-014 SHALL treat sop&eop in one cycle as a one-element packet: out_data = in_data, out_cnt = 1, state stays/returns IDLE.
REQ-015 SHALL, on avail without sop while IDLE, discard the element, pulse err one cycle, and stay IDLE.
REQ-016 SHALL, on avail with sop while ACC, pulse err, drop the partial packet without output, and restart with the new element.
REQ-017 SHALL saturate cnt at 2**CNT_W-1; accumulation continues unaffected.
REQ-018 SHALL ignore in_sop/in_eop/in_data when in_avail = 0; idle cycles inside a packet are permitted.
REQ-019 SHALL assert out_avail for exactly one cycle per completed packet, IN_PIPE+OUT_PIPE+1 cycles after the eop input cycle (registered accumulator included).
REQ-020 SHALL align err with the cycle the offending element reaches the accumulator (IN_PIPE cycles after input), err is not delayed by OUT_PIPE.
REQ-021 SHALL hold out_data/out_cnt/out_side stable between out_avail pulses.
REQ-022 SHALL support back-to-back packets with zero gap (eop followed next cycle by sop) at full throughput.

Reset
REQ-023 SHALL on s_rst_n = 0 force state IDLE, out_avail 0, err 0, out_data 0, out_cnt 0, acc 0, cnt 0, and clear all pipeline valid bits.
REQ-024 SHALL reset out_side to 0 only when the side-data reset option is applied through the common side-delay helper; otherwise out_side is unspecified until the first packet.
REQ-025 SHALL, on reset mid-packet, discard the partial packet: no out_avail, no err after reset release.

Verification (OP_W=8, MOD_M=0xF1=241, IN_PIPE=OUT_PIPE=1)
REQ-026 SHALL verify packet 200,100,50 (sop on first, eop on last) -> out_data=109, out_cnt=3, out_avail one cycle, 3 cycles after eop.
REQ-027 SHALL verify wrap-around: packet 240,240 -> out_data=239; packet 240,1 -> out_data=0.
REQ-028 SHALL verify single-element sop&eop with 0xF0 -> out_data=240, out_cnt=1; then immediate next packet 5,6 -> 11, cnt 2.
REQ-029 SHALL verify errors: avail 7 without sop while IDLE -> err pulse, no output; sop mid-packet 10,20 then sop 3,eop 4 -> err pulse, single output 7, cnt 2.
REQ-030 SHALL verify reset asserted after elements 10,20 of an open packet, then eop element sent -> no out_avail, no err; next full packet computes correctly.
REQ-031 SHALL verify random packets (lengths 1..300, random gaps) against a modular-sum model, including cnt saturation with CNT_W=4 (20 elements -> out_cnt=15).

Source files
------------

// File: rtl/mod_acc.sv
// Streaming packet accumulator: per-packet sum of elements modulo MOD_M, element count and
// side data captured at sop, with a single-cycle protocol-error pulse.
module mod_acc #(
  parameter int              OP_W     = 64,
  parameter logic [OP_W-1:0] MOD_M    = {OP_W{1'b1}}
                                        - ({{(OP_W-1){1'b0}}, 1'b1} << (OP_W/2))
                                        + {{(OP_W-2){1'b0}}, 2'b10},
  parameter int              CNT_W    = 16,
  parameter bit              IN_PIPE  = 1'b1,
  parameter bit              OUT_PIPE = 1'b1,
  parameter int              SIDE_W   = 0,
  localparam int             SW       = (SIDE_W > 0) ? SIDE_W : 1
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic             in_avail,
  input  logic [OP_W-1:0]  in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [SW-1:0]    in_side,
  output logic             out_avail,
  output logic [OP_W-1:0]  out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic [SW-1:0]    out_side,
  output logic             err
);

  typedef struct packed {
    logic            avail;
    logic            sop;
    logic            eop;
    logic [OP_W-1:0] data;
    logic [SW-1:0]   side;
  } elem_t;

  typedef enum logic {IDLE, ACC} state_t;

  elem_t in_e, st_e;
  assign in_e = '{avail: in_avail, sop: in_sop, eop: in_eop, data: in_data, side: in_side};

  generate
    if (IN_PIPE) begin : g_in_reg
      always_ff @(posedge clk) begin
        if (!s_rst_n) st_e <= '0;
        else          st_e <= in_e;
      end
    end else begin : g_in_byp
      assign st_e = in_e;
    end
  endgenerate

  state_t            state, state_nx;
  logic [OP_W-1:0]   acc, acc_nx, sum;
  logic [OP_W:0]     c;
  logic [OP_W+1:0]   diff;
  logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
  logic [SW-1:0]     side, side_nx;
  logic              done, err_c;
  // Set by reset, cleared by the next sop: leftovers of a packet cut by reset drop silently.
  logic              resync, resync_nx;

  logic              res_vld;
  logic [OP_W-1:0]   res_data;
  logic [CNT_W-1:0]  res_cnt;
  logic [SW-1:0]     res_side;

  always_comb begin
    c       = {1'b0, acc} + {1'b0, st_e.data};
    diff    = {1'b0, c} - {2'b00, MOD_M};
    sum     = diff[OP_W+1] ? c[OP_W-1:0] : diff[OP_W-1:0];
    cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  end

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    cnt_nx    = cnt;
    side_nx   = side;
    resync_nx = resync;
    done      = 1'b0;
    err_c     = 1'b0;
    if (st_e.avail) begin
      if (st_e.sop) begin
        err_c     = (state == ACC);
        acc_nx    = st_e.data;
        cnt_nx    = CNT_W'(1);
        side_nx   = st_e.side;
        resync_nx = 1'b0;
        done      = st_e.eop;
        state_nx  = st_e.eop ? IDLE : ACC;
      end else if (state == ACC) begin
        acc_nx = sum;
        cnt_nx = cnt_inc;
        if (st_e.eop) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end else begin
        err_c = !resync;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      side     <= '0;
      resync   <= 1'b1;
      res_vld  <= 1'b0;
      res_data <= '0;
      res_cnt  <= '0;
      res_side <= '0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      cnt     <= cnt_nx;
      side    <= side_nx;
      resync  <= resync_nx;
      res_vld <= done;
      if (done) begin
        res_data <= acc_nx;
        res_cnt  <= cnt_nx;
        res_side <= side_nx;
      end
    end
  end

  assign err = err_c & s_rst_n;

  generate
    if (OUT_PIPE) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (!s_rst_n) begin
          out_avail <= 1'b0;
          out_data  <= '0;
          out_cnt   <= '0;
          out_side  <= '0;
        end else begin
          out_avail <= res_vld;
          if (res_vld) begin
            out_data <= res_data;
            out_cnt  <= res_cnt;
            out_side <= res_side;
          end
        end
      end
    end else begin : g_out_byp
      assign out_avail = res_vld;
      assign out_data  = res_data;
      assign out_cnt   = res_cnt;
      assign out_side  = res_side;
    end
  endgenerate

endmodule

// File: tb/tb_mod_acc.sv
// Scoreboard bench for mod_acc: OP_W=8, MOD_M=241, CNT_W=4 (saturates at 15), 8-bit side data.
module tb_mod_acc;
  localparam int MOD = 241;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       s_rst_n;
  logic       in_avail, in_sop, in_eop;
  logic [7:0] in_data, in_side;
  logic       out_avail, err;
  logic [7:0] out_data, out_side;
  logic [3:0] out_cnt;

  mod_acc #(.OP_W(8), .MOD_M(8'hF1), .CNT_W(4), .IN_PIPE(1'b1), .OUT_PIPE(1'b1), .SIDE_W(8)) dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .in_avail(in_avail), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_side(in_side),
    .out_avail(out_avail), .out_data(out_data), .out_cnt(out_cnt), .out_side(out_side), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int data; int cnt; int side; int cyc;} exp_t;
  exp_t exp_q[$];
  int   err_q[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result or an error pulse.
  int prev_out = 0;
  bit prev_ok = 0;
  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (out_avail) begin
      if (exp_q.size() == 0) chk("unexpected_out_avail", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_cnt", out_cnt, e.cnt);
        chk("out_side", out_side, e.side);
        chk("out_latency_cyc", cyc, e.cyc);
      end
    end else if (s_rst_n && prev_ok) begin
      chk("out_hold", {out_data, out_cnt, out_side}, prev_out);
    end
    if (err) begin
      if (err_q.size() == 0) chk("unexpected_err", 1, 0);
      else begin
        ec = err_q.pop_front();
        chk("err_cyc", cyc, ec);
      end
    end
    prev_out = {out_data, out_cnt, out_side};
    prev_ok  = s_rst_n;
  end

  // Reference model: packet contents as a running integer sum; result is sum % MOD.
  bit m_open = 0, m_quiet = 1;
  int m_sum = 0, m_n = 0, m_side = 0;

  task automatic elem(input bit sop, input bit eop, input int d, input int s);
    @(negedge clk);
    in_avail = 1'b1; in_sop = sop; in_eop = eop; in_data = 8'(d); in_side = 8'(s);
    if (sop) begin
      if (m_open) err_q.push_back(cyc + 1);
      m_quiet = 0; m_open = 1; m_sum = 0; m_n = 0; m_side = s;
    end else if (!m_open) begin
      if (!m_quiet) err_q.push_back(cyc + 1);
      return;
    end
    m_sum += d;
    m_n++;
    if (eop) begin
      exp_q.push_back('{m_sum % MOD, (m_n > CMAX) ? CMAX : m_n, m_side, cyc + 3});
      m_open = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_avail = 1'b0; in_sop = 1'($urandom); in_eop = 1'($urandom);
      in_data = 8'($urandom); in_side = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_rst_n = 1'b0; in_avail = 1'b0;
    m_open = 0; m_quiet = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_avail", out_avail, 0);
    chk("rst_err", err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_side", out_side, 0);
    s_rst_n = 1'b1;
  endtask

  task automatic rand_pkt(input int len);
    int s;
    for (int i = 0; i < len; i++) begin
      s = int'($urandom_range(255));
      elem(i == 0, i == len - 1, int'($urandom_range(MOD - 1)), s);
      if (i != len - 1 && $urandom_range(3) == 0) idle(int'($urandom_range(3)));
    end
  endtask

  initial begin
    in_avail = 0; in_sop = 0; in_eop = 0; in_data = 0; in_side = 0;
    s_rst_n = 0;
    do_reset();
    idle(2);

    elem(1, 0, 200, 11); elem(0, 0, 100, 0); elem(0, 1, 50, 0);      // -> 109, cnt 3
    idle(3);
    elem(1, 0, 240, 12); elem(0, 1, 240, 0);                         // -> 239
    elem(1, 0, 240, 13); elem(0, 1, 1, 0);                           // -> 0
    elem(1, 1, 8'hF0, 14);                                           // single element
    elem(1, 0, 5, 15); elem(0, 1, 6, 0);                             // -> 11, cnt 2
    idle(2);
    elem(0, 0, 7, 0);                                                // orphan -> err
    idle(2);
    elem(1, 0, 10, 16); elem(0, 0, 20, 0); elem(1, 0, 3, 17); elem(0, 1, 4, 0); // err, -> 7
    idle(5);

    elem(1, 0, 10, 18); elem(0, 0, 20, 0);
    do_reset();
    elem(0, 1, 30, 0);                                               // silent drop
    idle(2);
    elem(1, 0, 1, 19); elem(0, 0, 2, 0); elem(0, 1, 3, 0);           // -> 6
    idle(2);

    for (int i = 0; i < 20; i++) elem(i == 0, i == 19, 1, 20);       // cnt saturates at 15
    idle(2);

    for (int p = 0; p < 40; p++) begin
      rand_pkt(($urandom_range(4) == 0) ? int'($urandom_range(300, 1)) : int'($urandom_range(30, 1)));
      if ($urandom_range(1) == 1) idle(int'($urandom_range(4)));
    end
    idle(10);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog_timeout cyc=%0d limit=90000", cyc);
    $fatal(1);
  end
endmodule
